// File: rtl/fwht_sdf_stage.sv
// rtl/fwht_sdf_stage.sv - single-path delay-feedback radix-2 FWHT butterfly stage
module fwht_sdf_stage #(
    parameter int WIDTH   = 8,
    parameter int M_WIDTH = 2
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_data,
    output logic             o_valid,
    output logic [WIDTH:0]   o_data,
    output logic             o_sum
);

    localparam int D = 1 << M_WIDTH;
    localparam logic [M_WIDTH:0] LAST = '1;

    logic [WIDTH:0]     mem_q [D];
    logic [M_WIDTH:0]   cnt_q, cnt_d;
    logic               primed_q, primed_d;
    logic               valid_q, valid_d;
    logic [WIDTH:0]     data_q, data_d;
    logic               sum_q, sum_d;
    logic               mem_we;
    logic [WIDTH:0]     mem_wdata;

    logic               half;
    logic [M_WIDTH-1:0] addr;
    logic [WIDTH:0]     x;
    logic [WIDTH:0]     m;

    assign half = cnt_q[M_WIDTH];
    assign addr = cnt_q[M_WIDTH-1:0];
    assign x    = {i_data[WIDTH-1], i_data};
    assign m    = mem_q[addr];

    always_comb begin
        cnt_d     = cnt_q;
        primed_d  = primed_q;
        valid_d   = 1'b0;
        data_d    = data_q;
        sum_d     = sum_q;
        mem_we    = 1'b0;
        mem_wdata = x;
        if (i_valid) begin
            cnt_d  = cnt_q + 1'b1;
            mem_we = 1'b1;
            if (!half) begin
                // First half: stash the sample, release last frame's difference.
                mem_wdata = x;
                valid_d   = primed_q;
                if (primed_q) begin
                    data_d = m;
                    sum_d  = 1'b0;
                end
            end else begin
                valid_d   = 1'b1;
                data_d    = m + x;
                sum_d     = 1'b1;
                mem_wdata = m - x;
                if (cnt_q == LAST) begin
                    primed_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_q    <= '0;
            primed_q <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
            sum_q    <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            primed_q <= primed_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
            sum_q    <= sum_d;
        end
    end

    // Delay line is deliberately left out of reset.
    always_ff @(posedge i_clk) begin
        if (mem_we && !i_reset) begin
            mem_q[addr] <= mem_wdata;
        end
    end

    assign o_valid = valid_q;
    assign o_data  = data_q;
    assign o_sum   = sum_q;

endmodule

// File: tb/tb_fwht_sdf_stage.sv
// tb/tb_fwht_sdf_stage.sv - scoreboard bench for fwht_sdf_stage
module tb_fwht_sdf_stage;

    logic       i_clk = 1'b0;
    logic       i_reset = 1'b1;
    logic       i_valid = 1'b0;
    logic [7:0] i_data = '0;
    logic       o_valid;
    logic [8:0] o_data;
    logic       o_sum;

    int checks = 0;
    int failures = 0;

    logic [9:0] exp_q[$];
    logic       started = 1'b0;
    logic       rst_edge = 1'b1;
    logic [8:0] prev_data = '0;
    logic       prev_sum = 1'b0;

    fwht_sdf_stage #(.WIDTH(8), .M_WIDTH(2)) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_valid(i_valid),
        .i_data (i_data),
        .o_valid(o_valid),
        .o_data (o_data),
        .o_sum  (o_sum)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) rst_edge <= i_reset;

    // Monitor: pop an expectation for every valid output; check hold on idle cycles.
    always @(negedge i_clk) begin
        if (started) begin
            if (o_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output: got data=%0h sum=%0b, expected no output", o_data, o_sum);
                end else begin
                    logic [9:0] e;
                    e = exp_q.pop_front();
                    if ({o_sum, o_data} !== e) begin
                        failures++;
                        $display("FAIL output: got data=%0h sum=%0b, expected data=%0h sum=%0b",
                                 o_data, o_sum, e[8:0], e[9]);
                    end
                end
            end else if (!rst_edge) begin
                checks++;
                if ({o_sum, o_data} !== {prev_sum, prev_data}) begin
                    failures++;
                    $display("FAIL hold: got data=%0h sum=%0b, expected data=%0h sum=%0b",
                             o_data, o_sum, prev_data, prev_sum);
                end
            end
        end
        prev_data = o_data;
        prev_sum  = o_sum;
    end

    task automatic expect_out(input int v, input bit s);
        logic [31:0] t;
        t = v;
        exp_q.push_back({s, t[8:0]});
    endtask

    task automatic send(input int v, input bit gap);
        logic [31:0] t;
        t = v;
        i_valid = 1'b1;
        i_data  = t[7:0];
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
        if (gap) begin
            @(posedge i_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        checks++;
        if ({o_valid, o_sum, o_data} !== 11'd0) begin
            failures++;
            $display("FAIL reset_state: got valid=%0b sum=%0b data=%0h, expected all zero",
                     o_valid, o_sum, o_data);
        end
    endtask

    task automatic basic_sequence(input bit gap);
        for (int k = 1; k <= 4; k++) send(k, gap);
        expect_out(6, 1);  send(5, gap);
        expect_out(8, 1);  send(6, gap);
        expect_out(10, 1); send(7, gap);
        expect_out(12, 1); send(8, gap);
        for (int k = 0; k < 4; k++) begin
            expect_out(-4, 0);
            send(0, gap);
        end
        for (int k = 0; k < 4; k++) begin
            expect_out(0, 1);
            send(0, gap);
        end
    endtask

    task automatic drain_check(input string name);
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain: got %0d pending outputs, expected 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        int fr[8];
        int prev[8];
        bit have_prev;

        @(posedge i_clk);
        #1;
        do_reset();
        started = 1'b1;

        // Back-to-back, then gapped.
        basic_sequence(1'b0);
        drain_check("gapless");
        do_reset();
        basic_sequence(1'b1);
        drain_check("gapped");

        // Extreme values.
        do_reset();
        send(-128, 0); send(127, 0); send(0, 0); send(0, 0);
        expect_out(-256, 1); send(-128, 0);
        expect_out(-1, 1);   send(-128, 0);
        expect_out(0, 1);    send(0, 0);
        expect_out(0, 1);    send(0, 0);
        expect_out(0, 0);    send(0, 0);
        expect_out(255, 0);  send(0, 0);
        expect_out(0, 0);    send(0, 0);
        expect_out(0, 0);    send(0, 0);
        drain_check("extremes");

        // Reset after 6 samples of a frame.
        do_reset();
        send(10, 0); send(20, 0); send(30, 0); send(40, 0);
        expect_out(60, 1); send(50, 0);
        expect_out(80, 1); send(60, 0);
        do_reset();
        for (int k = 1; k <= 4; k++) send(k, 0);
        expect_out(6, 1);  send(5, 0);
        expect_out(8, 1);  send(6, 0);
        expect_out(10, 1); send(7, 0);
        expect_out(12, 1); send(8, 0);
        drain_check("midreset");

        // Three random frames plus drain, against a frame-level model.
        do_reset();
        have_prev = 1'b0;
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 8; k++) fr[k] = (f == 3) ? 0 : $signed($urandom_range(255, 0)) - 128;
            for (int k = 0; k < 8; k++) begin
                if (k < 4) begin
                    if (have_prev) expect_out(prev[k] - prev[k+4], 0);
                end else begin
                    expect_out(fr[k-4] + fr[k], 1);
                end
                if (f == 3 && k == 4) break;
                send(fr[k], 0);
            end
            if (f == 3) begin
                exp_q.pop_back();
                break;
            end
            prev = fr;
            have_prev = 1'b1;
        end
        drain_check("random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
